ps_axi_cmd_issuer: RTL and testbench
====================================

// Module: ps_axi_cmd_issuer
// PURPOSE
// PS-side command sequencer upstream of the axi_transmit -> axi_slave path.
// - Queues write/read commands in a small FIFO and issues them one at a time as
//   single-cycle send pulses to the waddr/wdata/raddr transmitters.
// - Waits for the matching wresp/rdata from the slave, with a timeout.
// - Returns one result per command, in order.
// PARAMETERS
// A_DATA_WIDTH   32   address width
// WD_DATA_WIDTH  32   write/read data width
// FIFO_DEPTH     4    command FIFO entries (>=2, power of 2)
// TIMEOUT        100  WAIT_RESP cycles before a command is failed
// PORTS
// clk            in   1     system clock
// rst            in   1     synchronous active-high reset
// cmd_valid      in   1     command present
// cmd_rdy        out  1     FIFO can accept (= !full)
// cmd_is_write   in   1     1 = write, 0 = read
// cmd_addr       in   A     command address
// cmd_wdata      in   WD    write data (ignored for reads)
// waddr, wdata   out  A/WD  to write transmitters; stable until next issue
// waddr_send     out  1     1-cycle pulse
// wdata_send     out  1     1-cycle pulse
// raddr          out  A     to read-address transmitter
// raddr_send     out  1     1-cycle pulse
// wresp_valid_in in   1     write response valid (from axi_slave)
// wresp_in       in   2     write response code
// rdata_valid_in in   1     read data valid
// rdata_in       in   WD    read data
// rresp_in       in   2     read response code
// ps_read_rdy    out  1     always 1 out of reset
// ps_wresp_rdy   out  1     always 1 out of reset
// result_valid   out  1     1-cycle pulse, one per command
// result_is_write out 1     type of completed command
// result_data    out  WD    read data (0 for writes)
// result_resp    out  2     response code; 2'b10 on timeout
// timeout_err    out  1     pulses with result_valid on timeout
// stray_cnt      out  8     saturating count of unexpected responses
// busy           out  1     state!=IDLE || FIFO non-empty
// BEHAVIOUR
// Reset
// - All outputs 0, including ps_read_rdy and ps_wresp_rdy.
// - FIFO emptied, state=IDLE.
// - An in-flight command is dropped with no result.
// FIFO
// - Push on cmd_valid && cmd_rdy.
// - Push and pop in the same cycle are allowed when not full.
// - Pop decisions use the registered count, so a push into an empty FIFO in
//   cycle N is popped in cycle N+1.
// FSM: IDLE / ISSUE / WAIT_RESP
// IDLE
// - If the FIFO is non-empty: pop the head into the cur_* registers.
// - Register the send pulse and waddr/wdata or raddr; go to ISSUE.
// ISSUE (one cycle)
// - Write: waddr_send=wdata_send=1. Read: raddr_send=1.
// - Load timer=TIMEOUT; go to WAIT_RESP.
// - Send pulse is high in cycle N+2 for a push in cycle N into an empty FIFO.
// WAIT_RESP
// - Waits for the response matching cur_is_write.
// - On the matching valid: capture data/resp.
// - result_valid is high the next cycle, then go to IDLE.
// - Otherwise: if timer==0, timeout (resp=2'b10, timeout_err=1 with
//   result_valid next cycle, then IDLE); else timer decrements.
// - A response in the same cycle that timer==0 wins over the timeout.
// - With send in cycle S and no response, the timeout result is in cycle
//   S+2+TIMEOUT.
// - The next command's send can occur at the earliest 1 cycle after
//   result_valid.
// Stray responses
// - Any wresp/rdata valid not matching WAIT_RESP and cur_is_write increments
//   stray_cnt.
// - stray_cnt saturates at 255. No result is produced.
// - Both valids in one WAIT_RESP cycle: the matching one completes the
//   command, the other counts as stray.
// Other rules
// - Results complete strictly in FIFO order.
// - result_data is 0 for writes.
// TESTING
// 1. Write 0x100/123; wresp=0 two cycles after the send pulse
//    -> waddr=0x100, wdata=123, single send pulses.
//    -> result_valid 1 cycle, is_write=1, resp=0.
// 2. Read 0x100; rdata_valid with 123, rresp=0
//    -> raddr_send single pulse, result_data=123, resp=0.
// 3. Withhold responses, push until cmd_rdy=0
//    -> exactly FIFO_DEPTH+1 commands accepted.
//    -> Releasing responses yields 5 results in push order.
// 4. Read, no response
//    -> timeout result at S+2+TIMEOUT, resp=2'b10, timeout_err=1.
//    -> Repeat with response at S+1+TIMEOUT -> normal result, no timeout_err.
// 5. wresp_valid while IDLE; rdata_valid during a write's WAIT_RESP
//    -> stray_cnt=2, no extra result_valid.
// 6. Assert rst mid-WAIT_RESP with 2 queued commands
//    -> all outputs 0, busy=0, no results.
//    -> A late response then increments stray_cnt.

Source files
------------

// File: rtl/ps_axi_cmd_issuer.sv
// ps_axi_cmd_issuer
// PS-side command sequencer that sits in front of the waddr/wdata/raddr
// transmitters of the AXI path.
// - Write/read commands are queued in a small FIFO.
// - Commands are issued one at a time as single-cycle send pulses.
// - The matching slave response (wresp or rdata) is awaited, with a timeout.
// - Exactly one result is returned per issued command, in queue order.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/cmd_rdy command handshake (cmd_rdy = FIFO not full)
//   cmd_is_write      1 = write, 0 = read
//   cmd_addr          command address
//   cmd_wdata         command write data (ignored for reads)
//   waddr, wdata      write address/data; held until the next write issue
//   waddr_send        1-cycle pulse
//   wdata_send        1-cycle pulse
//   raddr             read address; held until the next read issue
//   raddr_send        1-cycle pulse
//   wresp_valid_in    write response valid from the slave
//   wresp_in          write response code
//   rdata_valid_in    read response valid from the slave
//   rdata_in          read data
//   rresp_in          read response code
//   ps_read_rdy       constant 1 once out of reset
//   ps_wresp_rdy      constant 1 once out of reset
//   result_valid      1-cycle pulse per command
//   result_is_write   type of the completed command
//   result_data       read data (0 for writes)
//   result_resp       response code (2'b10 on timeout)
//   timeout_err       pulses together with result_valid on a timeout
//   stray_cnt         saturating count of responses nobody was waiting for
//   busy              a command is in flight or queued
module ps_axi_cmd_issuer #(
   parameter int A_DATA_WIDTH  = 32,
   parameter int WD_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int TIMEOUT       = 100
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_rdy,
   input  logic                     cmd_is_write,
   input  logic [A_DATA_WIDTH-1:0]  cmd_addr,
   input  logic [WD_DATA_WIDTH-1:0] cmd_wdata,
   output logic [A_DATA_WIDTH-1:0]  waddr,
   output logic [WD_DATA_WIDTH-1:0] wdata,
   output logic                     waddr_send,
   output logic                     wdata_send,
   output logic [A_DATA_WIDTH-1:0]  raddr,
   output logic                     raddr_send,
   input  logic                     wresp_valid_in,
   input  logic [1:0]               wresp_in,
   input  logic                     rdata_valid_in,
   input  logic [WD_DATA_WIDTH-1:0] rdata_in,
   input  logic [1:0]               rresp_in,
   output logic                     ps_read_rdy,
   output logic                     ps_wresp_rdy,
   output logic                     result_valid,
   output logic                     result_is_write,
   output logic [WD_DATA_WIDTH-1:0] result_data,
   output logic [1:0]               result_resp,
   output logic                     timeout_err,
   output logic [7:0]               stray_cnt,
   output logic                     busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int ENT_W = 1 + A_DATA_WIDTH + WD_DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_RESP = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Command FIFO storage and bookkeeping
   logic [ENT_W-1:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]         count_reg;
   logic [ENT_W-1:0]         head;
   logic                     head_is_write;
   logic [A_DATA_WIDTH-1:0]  head_addr;
   logic [WD_DATA_WIDTH-1:0] head_wdata;

   logic                     push, pop, full;
   logic                     ready_reg;
   logic                     cur_is_write_reg;
   logic [TMR_W-1:0]         timer_reg;
   logic                     load_timer, finish_ok, finish_tmo, match_valid;

   logic [A_DATA_WIDTH-1:0]  waddr_reg, raddr_reg;
   logic [WD_DATA_WIDTH-1:0] wdata_reg;
   logic                     wsend_reg, rsend_reg;
   logic                     result_valid_reg, result_is_write_reg, timeout_err_reg;
   logic [WD_DATA_WIDTH-1:0] result_data_reg;
   logic [1:0]               result_resp_reg;
   logic [7:0]               stray_cnt_reg;
   logic                     stray_w, stray_r;
   logic [8:0]               stray_sum;

   assign head          = fifo_mem[rd_ptr_reg];
   assign head_is_write = head[ENT_W-1];
   assign head_addr     = head[ENT_W-2 -: A_DATA_WIDTH];
   assign head_wdata    = head[WD_DATA_WIDTH-1:0];

   // ready_reg is low during reset and the first cycle after, so the FIFO
   // refuses commands until the block is fully out of reset.
   assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
   assign cmd_rdy = ready_reg && !full;
   assign push    = cmd_valid && cmd_rdy;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {cmd_is_write, cmd_addr, cmd_wdata};
      end
   end

   // Next-state logic; pop looks only at the registered count, so a command
   // pushed into an empty FIFO is popped one cycle later.
   assign match_valid = cur_is_write_reg ? wresp_valid_in : rdata_valid_in;

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      load_timer = 1'b0;
      finish_ok  = 1'b0;
      finish_tmo = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (count_reg != '0) begin
               pop        = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            load_timer = 1'b1;
            state_next = ST_WAIT_RESP;
         end
         ST_WAIT_RESP: begin
            // A response arriving on the last timer cycle still wins.
            if (match_valid) begin
               finish_ok  = 1'b1;
               state_next = ST_IDLE;
            end else if (timer_reg == '0) begin
               finish_tmo = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A response is stray unless it is the one the in-flight command awaits.
   assign stray_w   = wresp_valid_in && !((state_reg == ST_WAIT_RESP) && cur_is_write_reg);
   assign stray_r   = rdata_valid_in && !((state_reg == ST_WAIT_RESP) && !cur_is_write_reg);
   assign stray_sum = {1'b0, stray_cnt_reg} + 9'(stray_w) + 9'(stray_r);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg           <= ST_IDLE;
         wr_ptr_reg          <= '0;
         rd_ptr_reg          <= '0;
         count_reg           <= '0;
         ready_reg           <= 1'b0;
         cur_is_write_reg    <= 1'b0;
         timer_reg           <= '0;
         waddr_reg           <= '0;
         wdata_reg           <= '0;
         raddr_reg           <= '0;
         wsend_reg           <= 1'b0;
         rsend_reg           <= 1'b0;
         result_valid_reg    <= 1'b0;
         result_is_write_reg <= 1'b0;
         result_data_reg     <= '0;
         result_resp_reg     <= '0;
         timeout_err_reg     <= 1'b0;
         stray_cnt_reg       <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= 1'b1;
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

         // Send pulses are registered at pop, so they are high exactly in ISSUE.
         wsend_reg <= pop && head_is_write;
         rsend_reg <= pop && !head_is_write;
         if (pop) begin
            cur_is_write_reg <= head_is_write;
            if (head_is_write) begin
               waddr_reg <= head_addr;
               wdata_reg <= head_wdata;
            end else begin
               raddr_reg <= head_addr;
            end
         end

         if (load_timer) begin
            timer_reg <= TMR_W'(TIMEOUT);
         end else if (state_reg == ST_WAIT_RESP && !finish_ok && !finish_tmo) begin
            timer_reg <= timer_reg - 1'b1;
         end

         result_valid_reg <= finish_ok || finish_tmo;
         timeout_err_reg  <= finish_tmo;
         if (finish_ok) begin
            result_is_write_reg <= cur_is_write_reg;
            result_data_reg     <= cur_is_write_reg ? '0 : rdata_in;
            result_resp_reg     <= cur_is_write_reg ? wresp_in : rresp_in;
         end else if (finish_tmo) begin
            result_is_write_reg <= cur_is_write_reg;
            result_data_reg     <= '0;
            result_resp_reg     <= 2'b10;
         end

         stray_cnt_reg <= (stray_sum > 9'd255) ? 8'd255 : stray_sum[7:0];
      end
   end

   assign waddr           = waddr_reg;
   assign wdata           = wdata_reg;
   assign raddr           = raddr_reg;
   assign waddr_send      = wsend_reg;
   assign wdata_send      = wsend_reg;
   assign raddr_send      = rsend_reg;
   assign ps_read_rdy     = ready_reg;
   assign ps_wresp_rdy    = ready_reg;
   assign result_valid    = result_valid_reg;
   assign result_is_write = result_is_write_reg;
   assign result_data     = result_data_reg;
   assign result_resp     = result_resp_reg;
   assign timeout_err     = timeout_err_reg;
   assign stray_cnt       = stray_cnt_reg;
   assign busy            = (state_reg != ST_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_ps_axi_cmd_issuer.sv
// Testbench for ps_axi_cmd_issuer: randomized and directed commands, a
// response-generating slave model, and a scoreboard of expected results.
module tb_ps_axi_cmd_issuer;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int T = 16;

   logic          clk, rst;
   logic          cmd_valid, cmd_rdy, cmd_is_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata;
   logic          waddr_send, wdata_send, raddr_send;
   logic          wresp_valid_in, rdata_valid_in;
   logic [1:0]    wresp_in, rresp_in;
   logic [DW-1:0] rdata_in;
   logic          ps_read_rdy, ps_wresp_rdy;
   logic          result_valid, result_is_write, timeout_err, busy;
   logic [DW-1:0] result_data;
   logic [1:0]    result_resp;
   logic [7:0]    stray_cnt;

   ps_axi_cmd_issuer #(
      .A_DATA_WIDTH(AW), .WD_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(T)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd_is_write(cmd_is_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .waddr(waddr), .wdata(wdata), .waddr_send(waddr_send), .wdata_send(wdata_send),
      .raddr(raddr), .raddr_send(raddr_send),
      .wresp_valid_in(wresp_valid_in), .wresp_in(wresp_in),
      .rdata_valid_in(rdata_valid_in), .rdata_in(rdata_in), .rresp_in(rresp_in),
      .ps_read_rdy(ps_read_rdy), .ps_wresp_rdy(ps_wresp_rdy),
      .result_valid(result_valid), .result_is_write(result_is_write),
      .result_data(result_data), .result_resp(result_resp),
      .timeout_err(timeout_err), .stray_cnt(stray_cnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            push_cyc;
      logic          w;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct {
      int            cyc;
      logic          w;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          tmo;
   } exp_t;

   cmd_t cmd_q[$];
   exp_t exp_q[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int            cyc = 0;
   bit            rst_d = 1'b1;
   int            occ = 0;
   int            prev_res = -1000;
   bit            pend = 1'b0;
   bit            pend_w, pend_normal;
   int            pend_r_cyc, pend_res, pend_stray;
   logic [DW-1:0] pend_rdata;
   logic [1:0]    pend_resp;
   int            stray_model = 0;
   int            stray_prev = 0;
   logic [AW-1:0] last_waddr = '0, last_raddr = '0;
   logic [DW-1:0] last_wdata = '0;

   // Stimulus knobs
   int            fix_d = -1;
   int            fix_resp = -1;
   bit            use_fix_rdata = 1'b0;
   logic [DW-1:0] fix_rdata = '0;
   int            stray_sel = 0;
   int            fix_stray = 1;
   bit            allow_tmo = 1'b0;
   bit            force_w = 1'b0, force_r = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor / scoreboard, sampling on the falling edge
   cmd_t mc;
   exp_t me;
   int   mk, md, mlast, mexp;
   logic [2:0] msends;
   bit   mmatch_w, mmatch_r;

   always @(negedge clk) begin
      mk = cyc;
      if (rst_d) begin
         chk("reset_ctl", {cmd_rdy, waddr_send, wdata_send, raddr_send, ps_read_rdy,
                           ps_wresp_rdy, result_valid, result_is_write, result_resp,
                           timeout_err, stray_cnt, busy}, '0);
         chk("reset_data", {waddr, wdata, raddr, result_data}, '0);
      end else begin
         msends = {waddr_send, wdata_send, raddr_send};
         if (msends != 3'b000) begin
            if (cmd_q.size() == 0) begin
               chk("unexpected_send", 128'(msends), 128'd0);
            end else begin
               mc = cmd_q.pop_front();
               mexp = mc.push_cyc + 2;
               if (prev_res + 1 > mexp) mexp = prev_res + 1;
               chk("send_cycle", 128'(mk), 128'(mexp));
               chk("send_pulses", 128'(msends), mc.w ? 128'b110 : 128'b001);
               if (mc.w) begin
                  last_waddr = mc.addr;
                  last_wdata = mc.data;
               end else begin
                  last_raddr = mc.addr;
               end
               occ--;
               // Slave model: choose when (and whether) to answer.
               if (fix_d >= 0) md = fix_d;
               else if (allow_tmo && ($urandom % 8 == 0)) md = T + 2;
               else if ($urandom % 4 == 0) md = $urandom_range(1, T + 1);
               else md = $urandom_range(1, 4);
               pend = 1'b1;
               pend_w = mc.w;
               pend_normal = (md <= T + 1);
               pend_r_cyc = mk + md;
               pend_rdata = use_fix_rdata ? fix_rdata : DW'($urandom);
               pend_resp = (fix_resp >= 0) ? 2'(fix_resp) : 2'($urandom_range(0, 3));
               pend_res = pend_normal ? mk + md + 1 : mk + T + 2;
               mlast = pend_normal ? mk + md : mk + T + 1;
               if (stray_sel == 1 && ($urandom % 3 == 0)) pend_stray = mk + $urandom_range(1, mlast - mk);
               else if (stray_sel == 2) pend_stray = mk + fix_stray;
               else pend_stray = -1;
               me.cyc = pend_res;
               me.w = mc.w;
               me.data = (pend_normal && !mc.w) ? pend_rdata : '0;
               me.resp = pend_normal ? pend_resp : 2'b10;
               me.tmo = !pend_normal;
               exp_q.push_back(me);
               prev_res = pend_res;
            end
         end
         if (result_valid) begin
            if (exp_q.size() == 0) begin
               chk("extra_result", 128'd1, 128'd0);
            end else begin
               me = exp_q.pop_front();
               chk("result_cycle", 128'(mk), 128'(me.cyc));
               chk("result_fields", {result_is_write, result_data, result_resp, timeout_err},
                   {me.w, me.data, me.resp, me.tmo});
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < mk) begin
            chk("missing_result", 128'd0, 128'd1);
            void'(exp_q.pop_front());
         end
         chk("tmo_without_result", 128'(timeout_err && !result_valid), 128'd0);
         chk("addr_regs", {waddr, wdata, raddr}, {last_waddr, last_wdata, last_raddr});
         chk("cmd_rdy", 128'(cmd_rdy), 128'(occ < DEPTH));
         chk("busy", 128'(busy), 128'((occ > 0) || (pend && mk < pend_res)));
         chk("rdy_outs", {ps_read_rdy, ps_wresp_rdy}, 128'b11);
         chk("stray_cnt", 128'(stray_cnt), 128'(stray_prev));
      end

      if (rst) begin
         cmd_q.delete();
         exp_q.delete();
         occ = 0;
         prev_res = -1000;
         pend = 1'b0;
         stray_model = 0;
         stray_prev = 0;
         last_waddr = '0;
         last_wdata = '0;
         last_raddr = '0;
      end else begin
         mmatch_w = pend && pend_normal && pend_w && (mk == pend_r_cyc);
         mmatch_r = pend && pend_normal && !pend_w && (mk == pend_r_cyc);
         if (wresp_valid_in && !mmatch_w && stray_model < 255) stray_model++;
         if (rdata_valid_in && !mmatch_r && stray_model < 255) stray_model++;
         stray_prev = stray_model;
         if (cmd_valid && cmd_rdy) begin
            cmd_q.push_back('{mk, cmd_is_write, cmd_addr, cmd_wdata});
            occ++;
         end
         if (pend && mk >= pend_res) pend = 1'b0;
      end
      rst_d = rst;
      cyc++;
   end

   // Advance one cycle and drive the slave-side inputs for that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wresp_valid_in = 1'b0;
      rdata_valid_in = 1'b0;
      wresp_in = 2'($urandom);
      rresp_in = 2'($urandom);
      rdata_in = DW'($urandom);
      if (pend && pend_normal && cyc == pend_r_cyc) begin
         if (pend_w) begin
            wresp_valid_in = 1'b1;
            wresp_in = pend_resp;
         end else begin
            rdata_valid_in = 1'b1;
            rdata_in = pend_rdata;
            rresp_in = pend_resp;
         end
      end
      if (pend && cyc == pend_stray) begin
         if (pend_w) rdata_valid_in = 1'b1;
         else wresp_valid_in = 1'b1;
      end
      if (force_w) wresp_valid_in = 1'b1;
      if (force_r) rdata_valid_in = 1'b1;
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      cmd_is_write = w;
      cmd_addr = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      while (!cmd_rdy && n < 200) begin
         tick();
         cmd_valid = 1'b1;
         n++;
      end
      if (!cmd_rdy) chk("cmd_accept_timeout", 128'd0, 128'd1);
      tick();
   endtask

   task automatic drain();
      int n = 0;
      while ((cmd_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) chk("drain_timeout", 128'd0, 128'd1);
      tick();
      tick();
   endtask

   initial begin
      int acc;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_is_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      wresp_valid_in = 1'b0;
      rdata_valid_in = 1'b0;
      wresp_in = '0;
      rresp_in = '0;
      rdata_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tick();

      // Write 0x100/123 answered two cycles after the send pulse
      fix_d = 2;
      fix_resp = 0;
      send_cmd(1'b1, 32'h100, 32'd123);
      drain();

      // Read 0x100 returning 123
      fix_d = 1;
      use_fix_rdata = 1'b1;
      fix_rdata = 32'd123;
      send_cmd(1'b0, 32'h100, 32'd0);
      drain();

      // Fill until cmd_rdy drops while responses are held back
      fix_d = T + 1;
      fix_resp = -1;
      use_fix_rdata = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         cmd_is_write = 1'($urandom);
         cmd_addr = AW'($urandom);
         cmd_wdata = DW'($urandom);
         cmd_valid = 1'b1;
         if (!cmd_rdy) break;
         acc++;
         tick();
      end
      tick();
      chk("accepted_until_full", 128'(acc), 128'(DEPTH + 1));
      drain();

      // Timeout, then a response on the very last waiting cycle
      fix_d = T + 2;
      send_cmd(1'b0, 32'h200, 32'd0);
      drain();
      fix_d = T + 1;
      send_cmd(1'b0, 32'h204, 32'd0);
      drain();

      // Strays: wresp while idle, rdata during a write's wait
      force_w = 1'b1;
      tick();
      force_w = 1'b0;
      tick();
      fix_d = 5;
      stray_sel = 2;
      fix_stray = 2;
      send_cmd(1'b1, 32'h300, 32'hABCD);
      drain();
      stray_sel = 0;
      chk("stray_after_two", 128'(stray_cnt), 128'd2);

      // Reset while waiting with two commands queued
      fix_d = T + 1;
      send_cmd(1'b1, 32'h400, 32'd1);
      send_cmd(1'b0, 32'h404, 32'd0);
      send_cmd(1'b1, 32'h408, 32'd3);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      force_w = 1'b1;
      tick();
      force_w = 1'b0;
      repeat (4) tick();
      chk("stray_after_reset", 128'(stray_cnt), 128'd1);
      chk("busy_after_reset", 128'(busy), 128'd0);

      // Randomized traffic
      fix_d = -1;
      fix_resp = -1;
      stray_sel = 1;
      allow_tmo = 1'b1;
      for (int i = 0; i < 250; i++) begin
         if ($urandom % 2 == 0) send_cmd(1'($urandom), AW'($urandom), DW'($urandom));
         else tick();
      end
      drain();

      // Saturation of the stray counter
      stray_sel = 0;
      force_w = 1'b1;
      force_r = 1'b1;
      repeat (140) tick();
      force_w = 1'b0;
      force_r = 1'b0;
      tick();
      tick();
      chk("stray_saturated", 128'(stray_cnt), 128'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
